// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a separately registered Gray-code output and a
// one-cycle wrap pulse; bin and gray are updated together from the same next value.
module bin_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_cnt_step;
  logic [WIDTH-1:0] w_cnt_src;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_step_wrap;

  always_comb begin
    w_cnt_step  = up ? (r_cnt + ONE) : (r_cnt - ONE);
    w_step_wrap = up ? (r_cnt == ALL_ONES) : (r_cnt == '0);
    w_cnt_src   = load ? load_bin : w_cnt_step;
  end

  // Gray code of the value about to be written, so gray never lags bin.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign w_gray_next[gi] = w_cnt_src[gi] ^ w_cnt_src[gi+1];
    end
  endgenerate
  assign w_gray_next[WIDTH-1] = w_cnt_src[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_cnt  <= load_bin;
      r_gray <= w_gray_next;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_cnt_step;
      r_gray <= w_gray_next;
      r_wrap <= w_step_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bin  = r_cnt;
  assign gray = r_gray;
  assign wrap = r_wrap;

endmodule
